pcm_tx_scheduler: RTL and testbench

Single-clock transmit sequencer for the PCM/Hamming/FSK link. It accepts PCM bytes over a valid/ready handshake and Hamming(7,4)-encodes each nibble into a 14-bit character. It serialises the character at one bit per BIT_DIV clkIn cycles and marks character boundaries for the FSK modulator. Rate timing uses clock-enable strobes rather than derived clocks: one character is 14 × BIT_DIV cycles (448 at default).

---
 rtl/pcm_tx_scheduler_pkg.sv | 17 +
 rtl/pcm_tx_scheduler_enc.sv | 23 ++
 rtl/pcm_tx_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_pcm_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_tx_scheduler_pkg.sv
// Shared definitions for the PCM transmit scheduler.
// A character is two Hamming(7,4) codewords, high nibble first, sent MSB-first
// from a 14-bit shift register.
package pcm_tx_scheduler_pkg;

    localparam int CHAR_BITS       = 14;
    localparam int CODE_BITS       = 7;
    localparam int DEFAULT_BIT_DIV = 32;
    // Bit index runs 1..CHAR_BITS while a character is on the line.
    localparam int IDX_W           = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/pcm_tx_scheduler_enc.sv
// Hamming(7,4) encoder, purely combinational.
// Ports:
//   data_i [3:0] : nibble d3..d0
//   code_o [6:0] : codeword in transmit order, code_o[6] is sent first:
//                  {p1, p2, d0, p3, d1, d2, d3}
module hamming74_enc
    import pcm_tx_scheduler_pkg::*;
(
    input  logic [3:0]           data_i,
    output logic [CODE_BITS-1:0] code_o
);

    logic p1;
    logic p2;
    logic p3;

    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3];
    assign p3 = data_i[1] ^ data_i[2] ^ data_i[3];

    assign code_o = {p1, p2, data_i[0], p3, data_i[1], data_i[2], data_i[3]};

endmodule

// File: rtl/pcm_tx_scheduler.sv
// Transmit sequencer for the PCM/Hamming/FSK link.
// Accepts bytes on a valid/ready handshake, encodes both nibbles into a
// 14-bit character and serialises it at one bit per BIT_DIV clocks on a
// free-running global bit grid.
// Ports:
//   clkIn       : system clock
//   reset       : asynchronous active-low reset
//   in_data     : PCM byte, sampled when in_valid & in_ready
//   in_valid    : in_data valid
//   in_ready    : holding register empty
//   tx_bit      : registered serial bit to the FSK modulator
//   tx_active   : tx_bit carries a character bit
//   bit_tick    : last cycle of each bit period
//   frame_start : first cycle a character's first bit is driven
//   char_done   : coincides with the bit_tick ending the 14th bit
//
// state | meaning
// IDLE  | line quiet, waiting for a bit_tick with the holding register full
// SHIFT | character on the line, idx_q = bits already driven (1..14)
module pcm_tx_scheduler
    import pcm_tx_scheduler_pkg::*;
#(
    parameter int BIT_DIV = DEFAULT_BIT_DIV,
    parameter int CNT_W   = 5
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       bit_tick,
    output logic       frame_start,
    output logic       char_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAR_BITS);

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic [CHAR_BITS-1:0] hold_q;
    logic                 hold_valid_q;
    logic [CODE_BITS-1:0] code_hi;
    logic [CODE_BITS-1:0] code_lo;
    logic                 accept;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [CHAR_BITS-1:0] shreg_q;
    logic [CHAR_BITS-1:0] shreg_d;
    logic                 tx_bit_q;
    logic                 tx_bit_d;
    logic                 tx_active_q;
    logic                 tx_active_d;
    logic                 frame_start_q;
    logic                 frame_start_d;
    logic                 load;
    logic                 char_done_c;

    // Bit-period grid; runs in every state so all bits share one alignment.
    assign bit_tick = (cnt_q == CNT_LAST);
    assign cnt_d    = bit_tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    hamming74_enc u_enc_hi (
        .data_i (in_data[7:4]),
        .code_o (code_hi)
    );

    hamming74_enc u_enc_lo (
        .data_i (in_data[3:0]),
        .code_o (code_lo)
    );

    // Accept and transfer are mutually exclusive: a transfer needs
    // hold_valid_q=1, which holds in_ready low.
    assign in_ready = ~hold_valid_q;
    assign accept   = in_valid & ~hold_valid_q;

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (accept) begin
            hold_q       <= {code_hi, code_lo};
            hold_valid_q <= 1'b1;
        end else if (load) begin
            hold_valid_q <= 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shreg_d       = shreg_q;
        tx_bit_d      = tx_bit_q;
        tx_active_d   = tx_active_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        char_done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_bit_d    = 1'b0;
                tx_active_d = 1'b0;
                if (bit_tick && hold_valid_q) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (idx_q < IDX_LAST) begin
                        tx_bit_d = shreg_q[CHAR_BITS-1];
                        shreg_d  = {shreg_q[CHAR_BITS-2:0], 1'b0};
                        idx_d    = idx_q + 1'b1;
                    end else begin
                        char_done_c = 1'b1;
                        if (hold_valid_q) begin
                            load = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            idx_d       = '0;
                            tx_bit_d    = 1'b0;
                            tx_active_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by the IDLE start and the gapless back-to-back restart.
        if (load) begin
            state_d       = SHIFT;
            idx_d         = IDX_W'(1);
            tx_bit_d      = hold_q[CHAR_BITS-1];
            shreg_d       = {hold_q[CHAR_BITS-2:0], 1'b0};
            tx_active_d   = 1'b1;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shreg_q       <= '0;
            tx_bit_q      <= 1'b0;
            tx_active_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            tx_bit_q      <= tx_bit_d;
            tx_active_q   <= tx_active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tx_bit      = tx_bit_q;
    assign tx_active   = tx_active_q;
    assign frame_start = frame_start_q;
    assign char_done   = char_done_c;

endmodule

// File: tb/tb_pcm_tx_scheduler.sv
// Directed bench for pcm_tx_scheduler: a default (BIT_DIV=32) instance and
// a BIT_DIV=4 instance share the clock and input pins; sel picks which one
// is observed. Expected characters are hand-encoded constants.
module tb_pcm_tx_scheduler;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] in_data;
    logic       in_valid;

    logic a_ready, a_bit, a_active, a_tick, a_frame, a_done;
    logic b_ready, b_bit, b_active, b_tick, b_frame, b_done;

    pcm_tx_scheduler u_dut_a (
        .clkIn       (clk),
        .reset       (rst_a),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (a_ready),
        .tx_bit      (a_bit),
        .tx_active   (a_active),
        .bit_tick    (a_tick),
        .frame_start (a_frame),
        .char_done   (a_done)
    );

    pcm_tx_scheduler #(.BIT_DIV(4), .CNT_W(2)) u_dut_b (
        .clkIn       (clk),
        .reset       (rst_b),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (b_ready),
        .tx_bit      (b_bit),
        .tx_active   (b_active),
        .bit_tick    (b_tick),
        .frame_start (b_frame),
        .char_done   (b_done)
    );

    logic sel;
    wire  o_ready  = sel ? b_ready  : a_ready;
    wire  o_bit    = sel ? b_bit    : a_bit;
    wire  o_active = sel ? b_active : a_active;
    wire  o_tick   = sel ? b_tick   : a_tick;
    wire  o_frame  = sel ? b_frame  : a_frame;
    wire  o_done   = sel ? b_done   : a_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int div      = 32;
    int at;

    // Hand-encoded characters, first transmitted bit at [13].
    localparam logic [13:0] CH_01 = 14'b0000000_1110000;
    localparam logic [13:0] CH_FF = 14'b1111111_1111111;
    localparam logic [13:0] CH_A5 = 14'b0100101_1011010;
    localparam logic [13:0] CH_3C = 14'b0111100_1000011;
    localparam logic [13:0] CH_96 = 14'b0011001_1100110;
    localparam logic [13:0] CH_00 = 14'b0000000_0000000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for frame_start; optionally scramble in_data each cycle
    // while the holding register should be full.
    task automatic wait_frame(input bit scramble, output int found_at);
        int  n;
        bit  found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 2 * div + 4) begin
            if (o_frame) begin
                found = 1'b1;
            end else begin
                chk("idle_before_frame", o_active, 0);
                if (scramble) begin
                    chk("hold_full_ready", o_ready, 0);
                    in_data = 8'($urandom);
                end
                step();
                n++;
            end
        end
        chk("frame_timeout", found, 1);
        found_at = cyc;
    endtask

    // Called on the first-bit cycle; checks the whole character and returns
    // on the cycle after its last bit. in_valid is dropped after the first
    // cycle so a byte offered then is accepted exactly once.
    task automatic check_char(input logic [13:0] ch, input bit refilled);
        for (int k = 0; k < 14 * div; k++) begin
            chk("tx_bit",      o_bit,    ch[13 - k / div]);
            chk("tx_active",   o_active, 1);
            chk("frame_start", o_frame,  (k == 0));
            chk("char_done",   o_done,   (k == 14 * div - 1));
            chk("bit_tick",    o_tick,   ((k % div) == div - 1));
            chk("in_ready",    o_ready,  refilled ? (k == 0) : 1'b1);
            step();
            if (k == 0) in_valid = 1'b0;
        end
    endtask

    task automatic check_idle(input int n);
        for (int k = 0; k < n; k++) begin
            chk("idle_active", o_active, 0);
            chk("idle_bit",    o_bit,    0);
            chk("idle_frame",  o_frame,  0);
            chk("idle_ready",  o_ready,  1);
            step();
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        step();
        step();
        rst_a = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        sel      = 1'b0;
        div      = 32;

        // Quiet line after reset: ticks on the global grid only.
        reset_a();
        for (int k = 0; k < 100; k++) begin
            chk("t1_tick",   a_tick,   ((cyc % 32) == 31));
            chk("t1_active", a_active, 0);
            chk("t1_ready",  a_ready,  1);
            chk("t1_done",   a_done,   0);
            step();
        end

        // Single byte 0x01 accepted at cycle 2.
        reset_a();
        step();
        step();
        in_data  = 8'h01;
        in_valid = 1'b1;
        chk("t2_ready_pre", a_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t2_ready_held", a_ready, 0);
        wait_frame(1'b0, at);
        chk("t2_start_cycle", at, 32);
        check_char(CH_01, 1'b0);
        chk("t2_end_cycle", cyc, 480);
        check_idle(40);

        // Back-to-back 0xFF then 0xA5 with no gap.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_frame(1'b0, at);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        check_char(CH_FF, 1'b1);
        check_char(CH_A5, 1'b0);
        check_idle(40);

        // in_valid held high with changing data while the hold is full.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        wait_frame(1'b1, at);
        in_data = 8'h96;
        check_char(CH_3C, 1'b1);
        check_char(CH_96, 1'b0);
        check_idle(40);

        // Reset at bit 7 of a character with the hold register full.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_frame(1'b0, at);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6 * 32 + 4) step();
        chk("t5_pre_active", a_active, 1);
        chk("t5_pre_bit",    a_bit,    1);
        chk("t5_pre_ready",  a_ready,  0);
        rst_a = 1'b0;
        #1;
        chk("t5_rst_bit",    a_bit,    0);
        chk("t5_rst_active", a_active, 0);
        chk("t5_rst_frame",  a_frame,  0);
        chk("t5_rst_done",   a_done,   0);
        chk("t5_rst_tick",   a_tick,   0);
        step();
        step();
        rst_a = 1'b1;
        cyc   = 0;
        check_idle(100);

        // BIT_DIV=4 instance, byte 0x00.
        sel   = 1'b1;
        div   = 4;
        rst_b = 1'b1;
        cyc   = 0;
        in_data  = 8'h00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_frame(1'b0, at);
        chk("t6_start_cycle", at, 4);
        check_char(CH_00, 1'b0);
        check_idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
